// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: control-side start/redirect, instruction-memory read port and IR load outputs.
// The fetch unit takes the slave modport; the controller/memory side takes master.
interface instruction_fetch_unit_if;
    logic        start;
    logic        pc_write;
    logic [31:0] pc_next;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] ir_d;
    logic        ir_enable;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        busy;
    logic        done;
    logic        fetch_err;
    logic        addr_err;

    modport slave (
        input  start, pc_write, pc_next, mem_ready, mem_rdata,
        output mem_rd, mem_addr, ir_d, ir_enable, pc, pc_plus4,
               busy, done, fetch_err, addr_err
    );

    modport master (
        output start, pc_write, pc_next, mem_ready, mem_rdata,
        input  mem_rd, mem_addr, ir_d, ir_enable, pc, pc_plus4,
               busy, done, fetch_err, addr_err
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Multi-cycle fetch engine: IDLE -> REQ (wait for mem_ready, abort after WAIT_LIMIT) -> LOAD -> IDLE.
// start to ir_enable is 2 cycles plus one per memory wait cycle; start/pc_write ignored while busy.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          WAIT_LIMIT = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [7:0]  r_wait;
    logic        r_fetch_err;
    logic        r_addr_err;
    logic [31:0] w_pc_plus4;
    logic        w_timeout;
    logic        w_mem_rd;
    logic        w_ir_enable;
    logic        w_busy;

    assign w_pc_plus4 = r_pc + 32'd4;
    // Abort on the WAIT_LIMIT-th consecutive REQ cycle that sees no ready.
    assign w_timeout  = (r_state == S_REQ) && !bus.mem_ready && (r_wait == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_state_nxt = S_REQ;
            S_REQ: begin
                if (bus.mem_ready)  w_state_nxt = S_LOAD;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_LOAD:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_mem_rd    = 1'b0;
        w_ir_enable = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_REQ: begin
                w_mem_rd = 1'b1;
                w_busy   = 1'b1;
            end
            S_LOAD: begin
                w_ir_enable = 1'b1;
                w_busy      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_ir        <= 32'd0;
            r_wait      <= 8'd0;
            r_fetch_err <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_fetch_err <= w_timeout;
            r_addr_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Redirect lands at this edge, so a simultaneous start fetches the new PC.
                    if (bus.pc_write) begin
                        r_pc       <= {bus.pc_next[31:2], 2'b00};
                        r_addr_err <= |bus.pc_next[1:0];
                    end
                    if (bus.start) r_wait <= 8'd0;
                end
                S_REQ: begin
                    if (bus.mem_ready) r_ir   <= bus.mem_rdata;
                    else               r_wait <= r_wait + 8'd1;
                end
                S_LOAD:  r_pc <= w_pc_plus4;
                default: ;
            endcase
        end
    end

    assign bus.mem_rd    = w_mem_rd;
    assign bus.mem_addr  = r_pc;
    assign bus.ir_d      = r_ir;
    assign bus.ir_enable = w_ir_enable;
    assign bus.done      = w_ir_enable;
    assign bus.pc        = r_pc;
    assign bus.pc_plus4  = w_pc_plus4;
    assign bus.busy      = w_busy;
    assign bus.fetch_err = r_fetch_err;
    assign bus.addr_err  = r_addr_err;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: one task per scenario, inline checks, single summary.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .WAIT_LIMIT (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.start     = 1'b0;
        bus.pc_write  = 1'b0;
        bus.pc_next   = 32'd0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 32'h0); end
        n_cmp++; if (bus.ir_d !== 32'h0) begin n_fail++; $display("FAIL reset_ir_d got=%h exp=%h", bus.ir_d, 32'h0); end
        n_cmp++; if (bus.pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc_plus4 got=%h exp=%h", bus.pc_plus4, 32'h4); end
        n_cmp++; if ({bus.mem_rd, bus.busy, bus.ir_enable, bus.done, bus.fetch_err, bus.addr_err} !== 6'b0) begin
            n_fail++; $display("FAIL reset_strobes got=%b exp=%b",
                {bus.mem_rd, bus.busy, bus.ir_enable, bus.done, bus.fetch_err, bus.addr_err}, 6'b0);
        end
    endtask

    task automatic test_basic_fetch;
        bus.start     = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hAF31_AF31;
        tick();
        bus.start = 1'b0;
        n_cmp++; if ({bus.mem_rd, bus.busy, bus.ir_enable} !== 3'b110) begin n_fail++; $display("FAIL basic_req got=%b exp=%b", {bus.mem_rd, bus.busy, bus.ir_enable}, 3'b110); end
        n_cmp++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_addr got=%h exp=%h", bus.mem_addr, 32'h0); end
        tick();
        bus.mem_ready = 1'b0;
        n_cmp++; if ({bus.ir_enable, bus.done, bus.mem_rd} !== 3'b110) begin n_fail++; $display("FAIL basic_load got=%b exp=%b", {bus.ir_enable, bus.done, bus.mem_rd}, 3'b110); end
        n_cmp++; if (bus.ir_d !== 32'hAF31_AF31) begin n_fail++; $display("FAIL basic_ir_d got=%h exp=%h", bus.ir_d, 32'hAF31_AF31); end
        tick();
        n_cmp++; if (bus.pc !== 32'h4) begin n_fail++; $display("FAIL basic_pc got=%h exp=%h", bus.pc, 32'h4); end
        n_cmp++; if ({bus.ir_enable, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL basic_idle got=%b exp=%b", {bus.ir_enable, bus.busy}, 2'b00); end
    endtask

    task automatic test_wait_states;
        int rd_cycles = 0;
        int en_cnt = 0;
        bus.start     = 1'b1;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h1234_5678;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bus.mem_rd === 1'b1 && bus.mem_addr === 32'h4) rd_cycles++;
            tick();
        end
        bus.mem_ready = 1'b1;
        if (bus.mem_rd === 1'b1 && bus.mem_addr === 32'h4) rd_cycles++;
        tick();
        bus.mem_ready = 1'b0;
        n_cmp++; if (rd_cycles !== 4) begin n_fail++; $display("FAIL wait_rd_cycles got=%0d exp=%0d", rd_cycles, 4); end
        n_cmp++; if (bus.ir_d !== 32'h1234_5678) begin n_fail++; $display("FAIL wait_ir_d got=%h exp=%h", bus.ir_d, 32'h1234_5678); end
        for (int i = 0; i < 3; i++) begin
            if (bus.ir_enable === 1'b1) en_cnt++;
            tick();
        end
        n_cmp++; if (en_cnt !== 1) begin n_fail++; $display("FAIL wait_enable_count got=%0d exp=%0d", en_cnt, 1); end
        n_cmp++; if (bus.pc !== 32'h8) begin n_fail++; $display("FAIL wait_pc got=%h exp=%h", bus.pc, 32'h8); end
    endtask

    task automatic test_pc_write;
        bus.pc_write  = 1'b1;
        bus.pc_next   = 32'h100;
        bus.start     = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.pc_write = 1'b0;
        bus.start    = 1'b0;
        n_cmp++; if (bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL pcw_addr got=%h exp=%h", bus.mem_addr, 32'h100); end
        n_cmp++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL pcw_addr_err_aligned got=%b exp=%b", bus.addr_err, 1'b0); end
        tick();
        bus.mem_ready = 1'b0;
        tick();
        n_cmp++; if (bus.pc !== 32'h104) begin n_fail++; $display("FAIL pcw_pc_after got=%h exp=%h", bus.pc, 32'h104); end
        bus.pc_write = 1'b1;
        bus.pc_next  = 32'h103;
        tick();
        bus.pc_write = 1'b0;
        n_cmp++; if (bus.addr_err !== 1'b1) begin n_fail++; $display("FAIL pcw_addr_err got=%b exp=%b", bus.addr_err, 1'b1); end
        n_cmp++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL pcw_misaligned_pc got=%h exp=%h", bus.pc, 32'h100); end
        tick();
        n_cmp++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL pcw_addr_err_pulse got=%b exp=%b", bus.addr_err, 1'b0); end
    endtask

    task automatic test_timeout;
        int rd_cycles = 0;
        int en_cnt = 0;
        int early_err = 0;
        bus.start     = 1'b1;
        bus.mem_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (bus.mem_rd === 1'b1) rd_cycles++;
            if (bus.fetch_err === 1'b1) early_err++;
            if (bus.ir_enable === 1'b1) en_cnt++;
            tick();
        end
        n_cmp++; if (rd_cycles !== 15) begin n_fail++; $display("FAIL to_rd_cycles got=%0d exp=%0d", rd_cycles, 15); end
        n_cmp++; if (early_err !== 0) begin n_fail++; $display("FAIL to_early_err got=%0d exp=%0d", early_err, 0); end
        n_cmp++; if ({bus.fetch_err, bus.mem_rd, bus.busy} !== 3'b100) begin n_fail++; $display("FAIL to_abort got=%b exp=%b", {bus.fetch_err, bus.mem_rd, bus.busy}, 3'b100); end
        n_cmp++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL to_pc got=%h exp=%h", bus.pc, 32'h100); end
        n_cmp++; if (bus.ir_d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_ir_d got=%h exp=%h", bus.ir_d, 32'hDEAD_BEEF); end
        if (bus.ir_enable === 1'b1) en_cnt++;
        tick();
        if (bus.ir_enable === 1'b1) en_cnt++;
        n_cmp++; if (bus.fetch_err !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse got=%b exp=%b", bus.fetch_err, 1'b0); end
        n_cmp++; if (en_cnt !== 0) begin n_fail++; $display("FAIL to_no_enable got=%0d exp=%0d", en_cnt, 0); end
    endtask

    task automatic test_reset_in_req;
        bus.start     = 1'b1;
        bus.mem_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        n_cmp++; if (bus.mem_rd !== 1'b1) begin n_fail++; $display("FAIL rreq_in_req got=%b exp=%b", bus.mem_rd, 1'b1); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if ({bus.mem_rd, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL rreq_rd_drop got=%b exp=%b", {bus.mem_rd, bus.busy}, 2'b00); end
        n_cmp++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL rreq_pc got=%h exp=%h", bus.pc, 32'h0); end
        n_cmp++; if (bus.ir_d !== 32'h0) begin n_fail++; $display("FAIL rreq_ir_d got=%h exp=%h", bus.ir_d, 32'h0); end
    endtask

    task automatic test_wrap;
        bus.pc_write  = 1'b1;
        bus.pc_next   = 32'hFFFF_FFFC;
        bus.start     = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0BAD_F00D;
        tick();
        bus.pc_write = 1'b0;
        bus.start    = 1'b0;
        n_cmp++; if (bus.mem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr got=%h exp=%h", bus.mem_addr, 32'hFFFF_FFFC); end
        n_cmp++; if (bus.pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_plus4 got=%h exp=%h", bus.pc_plus4, 32'h0); end
        tick();
        bus.mem_ready = 1'b0;
        n_cmp++; if (bus.ir_d !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL wrap_ir_d got=%h exp=%h", bus.ir_d, 32'h0BAD_F00D); end
        tick();
        n_cmp++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got=%h exp=%h", bus.pc, 32'h0); end
        n_cmp++; if ({bus.fetch_err, bus.addr_err} !== 2'b00) begin n_fail++; $display("FAIL wrap_flags got=%b exp=%b", {bus.fetch_err, bus.addr_err}, 2'b00); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic_fetch();
        test_wait_states();
        test_pc_write();
        test_timeout();
        test_reset_in_req();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
